pc_seq_ctrl: RTL

Sequencer for the program-counter source multiplexer and PC/EPC write enables in the multicycle MIPS datapath. Once per instruction, it accepts the control unit's PC-update request and drives the mux select, which picks one of: memory data, ALU result, ALU-out register, current PC, shifted jump target, or EPC. On exceptions it captures EPC, reads the handler vector from memory with a fixed latency, and loads it into the PC.

---
 rtl/pc_seq_ctrl_if.sv | 24 ++
 rtl/pc_seq_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl_if.sv
// pc_seq_ctrl_if: PC-update request and PC/EPC control bundle between control unit and sequencer
interface pc_seq_ctrl_if;
  logic        start;
  logic [2:0]  kind;
  logic        cond;
  logic        exc_opc;
  logic        exc_ovf;
  logic        exc_div0;
  logic [2:0]  sel;
  logic        pc_write;
  logic        epc_write;
  logic        vec_rd;
  logic [31:0] vec_addr;
  logic        busy;
  logic        done;
  modport master (
    output start, kind, cond, exc_opc, exc_ovf, exc_div0,
    input  sel, pc_write, epc_write, vec_rd, vec_addr, busy, done
  );
  modport slave (
    input  start, kind, cond, exc_opc, exc_ovf, exc_div0,
    output sel, pc_write, epc_write, vec_rd, vec_addr, busy, done
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: PC source mux / PC+EPC write sequencer with exception vector fetch
module pc_seq_ctrl #(
  parameter int unsigned MEM_LAT = 2,
  parameter logic [31:0] VEC_OPC = 32'd253,
  parameter logic [31:0] VEC_OVF = 32'd254,
  parameter logic [31:0] VEC_DIV = 32'd255
) (
  input logic          clk,
  input logic          reset,
  pc_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, UPD, EXC, WAIT, LOAD} state_e;
  state_e      state_q, state_d;
  logic [2:0]  kind_q, kind_d;
  logic        cond_q, cond_d;
  logic [31:0] vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d, upd_sel;
  logic        pc_write_q, pc_write_d;
  logic        epc_write_q, epc_write_d;
  logic        vec_rd_q, vec_rd_d;
  logic [31:0] vec_addr_q, vec_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        illegal, exc;
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cond_d  = cond_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    illegal = bus.kind > 3'd4;
    exc     = bus.exc_opc | bus.exc_ovf | bus.exc_div0 | illegal;
    case (state_q)
      // busy_q still reflects the final UPD/LOAD output cycle, so a start
      // overlapping that cycle is dropped rather than accepted early
      IDLE: if (bus.start && !busy_q) begin
        kind_d  = bus.kind;
        cond_d  = bus.cond;
        vec_d   = (bus.exc_opc || illegal) ? VEC_OPC : bus.exc_ovf ? VEC_OVF : VEC_DIV;
        state_d = exc ? EXC : UPD;
      end
      EXC: begin
        cnt_d   = 4'(MEM_LAT - 1);
        state_d = (MEM_LAT == 1) ? LOAD : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? LOAD : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    upd_sel     = (kind_q == 3'd0 || kind_q == 3'd3) ? 3'b001 :
                  (kind_q == 3'd1) ? (cond_q ? 3'b010 : 3'b011) :
                  (kind_q == 3'd2) ? 3'b100 : 3'b101;
    sel_d       = (state_q == UPD) ? upd_sel : (state_q == LOAD) ? 3'b000 : 3'b011;
    pc_write_d  = (state_q == UPD && !(kind_q == 3'd1 && !cond_q)) || state_q == LOAD;
    epc_write_d = state_q == EXC;
    vec_rd_d    = state_q == EXC;
    vec_addr_d  = (state_q == EXC) ? vec_q : vec_addr_q;
    busy_d      = state_q != IDLE;
    done_d      = state_q == UPD || state_q == LOAD;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      kind_q      <= 3'd0;
      cond_q      <= 1'b0;
      vec_q       <= 32'd0;
      cnt_q       <= 4'd0;
      sel_q       <= 3'b011;
      pc_write_q  <= 1'b0;
      epc_write_q <= 1'b0;
      vec_rd_q    <= 1'b0;
      vec_addr_q  <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      cond_q      <= cond_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      pc_write_q  <= pc_write_d;
      epc_write_q <= epc_write_d;
      vec_rd_q    <= vec_rd_d;
      vec_addr_q  <= vec_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign bus.sel       = sel_q;
  assign bus.pc_write  = pc_write_q;
  assign bus.epc_write = epc_write_q;
  assign bus.vec_rd    = vec_rd_q;
  assign bus.vec_addr  = vec_addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  a_pc_epc_excl: assert property (@(posedge clk) !(pc_write_q && epc_write_q));
endmodule
